// File: rtl/mpsoc_msi_wb_cc561_arb.sv
// Round-robin scheduler sharing one cc561 clock-crossing channel between NREQ
// requesters. The channel has no acknowledge, so every issue is followed by a
// fixed HOLD window of GAP cycles before the next grant can be made.
module mpsoc_msi_wb_cc561_arb #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned GAP  = 4,
  localparam int unsigned IW  = $clog2(NREQ)
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 en,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 aen,
  output logic [IW+DW-1:0]     adata,
  output logic                 busy
);

  // Hold counter is at least 4 bits and always wide enough to hold GAP.
  localparam int unsigned CW = ($clog2(GAP + 1) > 4) ? $clog2(GAP + 1) : 4;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [IW-1:0]     last_q;
  logic              aen_q;
  logic [IW+DW-1:0]  adata_q;

  logic              win_hit;
  logic [IW-1:0]     win_id;
  logic [DW-1:0]     win_data;
  logic              accept;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    win_hit  = 1'b0;
    win_id   = '0;
    win_data = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned idx;
      idx = (int'(last_q) + k) % NREQ;
      if (!win_hit && req_valid[idx]) begin
        win_hit  = 1'b1;
        win_id   = idx[IW-1:0];
        win_data = req_data[idx*DW +: DW];
      end
    end
  end

  // Grant strobe: only in IDLE, enabled and out of reset.
  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && en && !wb_rst_i && win_hit) begin
      req_ready[win_id] = 1'b1;
    end
  end

  assign accept = |req_ready;

  // Scheduler FSM with registered issue pulse and payload.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      aen_q   <= 1'b0;
      adata_q <= '0;
    end else begin
      aen_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StHold;
            cnt_q   <= CW'(GAP);
            last_q  <= win_id;
            aen_q   <= 1'b1;
            adata_q <= {win_id, win_data};
          end
        end
        StHold: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign aen   = aen_q;
  assign adata = adata_q;
  assign busy  = (state_q == StHold) && !wb_rst_i;

endmodule

// File: tb/tb_mpsoc_msi_wb_cc561_arb.sv
// Randomized scoreboard bench for the cc561 round-robin scheduler.
module tb_mpsoc_msi_wb_cc561_arb;

  localparam int unsigned DW   = 8;
  localparam int unsigned NREQ = 4;
  localparam int unsigned GAP  = 3;
  localparam int unsigned IW   = $clog2(NREQ);
  localparam int          NCYC = 2400;

  logic                wb_clk_i = 1'b0;
  logic                wb_rst_i = 1'b1;
  logic                en = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*DW-1:0]  req_data = '0;
  logic [NREQ-1:0]     req_ready;
  logic                aen;
  logic [IW+DW-1:0]    adata;
  logic                busy;

  mpsoc_msi_wb_cc561_arb #(
    .DW   (DW),
    .NREQ (NREQ),
    .GAP  (GAP)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .en        (en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .aen       (aen),
    .adata     (adata),
    .busy      (busy)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    int               cyc;
    logic [IW+DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_on = 1'b0;
  bit   stop_mon = 1'b0;

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // Monitor: every issue pulse must match the oldest pending expectation.
  initial begin : monitor
    logic [IW+DW-1:0] adata_exp;
    bit               prev_rst;
    adata_exp = '0;
    prev_rst  = 1'b1;
    while (!stop_mon) begin
      @(negedge wb_clk_i);
      if (mon_on) begin
        if (prev_rst) adata_exp = '0;
        if (aen) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL aen_unexpected cyc=%0d actual adata=%h required no pulse", cyc, adata);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            adata_exp = e.data;
            if (e.cyc != cyc) begin
              n_err++;
              $display("FAIL aen_timing actual cyc=%0d required cyc=%0d", cyc, e.cyc);
            end
          end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          exp_t e;
          e = exp_q.pop_front();
          n_cmp++;
          n_err++;
          $display("FAIL aen_missing cyc=%0d actual aen=0 required aen=1 adata=%h", cyc, e.data);
        end
        n_cmp++;
        if (adata !== adata_exp) begin
          n_err++;
          $display("FAIL adata cyc=%0d actual %h required %h", cyc, adata, adata_exp);
        end
      end
      prev_rst = wb_rst_i;
    end
  end

  // Driver + reference model: tracks last grant and the cycle from which the
  // next grant is allowed; computes the expected strobe and issue from the rules.
  initial begin : driver
    int last_w;
    int acc_cyc;
    int block_until;
    int mode;
    logic [NREQ-1:0] exp_ready;
    bit exp_busy;
    last_w      = NREQ - 1;
    acc_cyc     = -100;
    block_until = 0;

    for (int t = 0; t < NCYC + GAP + 4; t++) begin
      @(posedge wb_clk_i);
      #1;
      if (t < 3) begin
        wb_rst_i = 1'b1;
      end else if (t < NCYC) begin
        mode      = (t / 150) % 4;
        wb_rst_i  = ($urandom_range(0, 59) == 0);
        en        = (mode == 3) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) != 0);
        case (mode)
          1:       req_valid = '1;
          2: begin
            for (int i = 0; i < NREQ; i++) req_valid[i] = ($urandom_range(0, 3) == 0);
          end
          default: req_valid = NREQ'($urandom);
        endcase
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'($urandom);
      end else begin
        wb_rst_i  = 1'b0;
        req_valid = '0;
      end
      mon_on = (t >= 1);

      @(negedge wb_clk_i);
      exp_ready = '0;
      exp_busy  = 1'b0;
      if (wb_rst_i) begin
        last_w      = NREQ - 1;
        acc_cyc     = -100;
        block_until = cyc + 1;
      end else begin
        exp_busy = (cyc > acc_cyc) && (cyc < block_until);
        if (en && cyc >= block_until) begin
          for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last_w + k) % NREQ;
            if (exp_ready == '0 && req_valid[i]) begin
              exp_t e;
              exp_ready[i] = 1'b1;
              e.cyc  = cyc + 1;
              e.data = {IW'(i), req_data[i*DW +: DW]};
              exp_q.push_back(e);
              last_w      = i;
              acc_cyc     = cyc;
              block_until = cyc + GAP + 1;
            end
          end
        end
      end
      if (t >= 1) begin
        n_cmp++;
        if (req_ready !== exp_ready) begin
          n_err++;
          $display("FAIL req_ready cyc=%0d actual %b required %b", cyc, req_ready, exp_ready);
        end
        n_cmp++;
        if (busy !== exp_busy) begin
          n_err++;
          $display("FAIL busy cyc=%0d actual %b required %b", cyc, busy, exp_busy);
        end
      end
    end

    @(negedge wb_clk_i);
    stop_mon = 1'b1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain actual %0d pending issues required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
